node_stripe_gen: RTL and testbench
==================================

Name: node_stripe_gen

Overview:
Parametrised successor to the 8-lane node stripe: LANES lanes of sign-magnitude fixed-point ALUs that share one tag-matching operand-capture controller. The block is configured once per job, then captures operand blocks from a broadcast bus by tag, with tags advancing by a stride after every step. It accumulates for iter_lim steps and presents the result over a valid/ready handshake. Stripes are daisy-chained via prev_enable/next_enable for job allocation inside a node.

Parameters:
LANES, 8, number of lanes per stripe
DATA_W, 16, lane word width, sign-magnitude (bit DATA_W-1 = sign)
FRAC_W, 8, fractional bits in the magnitude
TAG_W, 12, tag/stride/iteration-count width
ACC_W, 2*DATA_W, two's-complement accumulator width per lane

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
prev_enable  in  1  allocation token from the previous stripe
next_enable  out  1  prev_enable & (state != IDLE)
cfg_valid  in  1  job config offered
cfg_ready  out  1  prev_enable & (state == IDLE)
cfg_op  in  2  00 ADD, 01 SUB, 10 MUL, 11 ABSDIFF
cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b, cfg_iter_lim  in  TAG_W each  job descriptor
bus_valid  in  1  broadcast operand word valid
bus_tag  in  TAG_W  tag of the bus word
bus_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
match_drop  out  1  pulse: a tag match was ignored this cycle
out_valid  out  1  result available
out_ready  in  1  result consumer ready
out_data  out  LANES*DATA_W  sign-magnitude results

Behaviour:
- Reset: state IDLE; all accumulators, flags and tag registers 0; out_valid = 0, out_data = 0, match_drop = 0, next_enable = 0, cfg_ready follows prev_enable.
- States: IDLE, WAIT, DONE.
- IDLE: when cfg_valid & cfg_ready, latch the descriptor, clear accumulators, iter_count and capture flags. Go to WAIT, or to DONE if cfg_iter_lim == 0 (result 0).
- WAIT, capture: when bus_valid and bus_tag == tag_a and a_ok == 0, latch A and set a_ok. The same rule with tag_b/b_ok latches B. A single word may satisfy both.
- WAIT, step: the cycle after a_ok & b_ok are both set, every lane performs acc += f(A,B). In the same cycle: a_ok = b_ok = 0; tag_a += stride_a and tag_b += stride_b, both mod 2^TAG_W; iter_count++.
- WAIT, step-cycle matches: any tag match during the step cycle is ignored and match_drop = 1. The producer must resend.
- WAIT, exit: when iter_count reaches iter_lim, state goes to DONE one cycle after the final step.
- Operand conversion: sign-magnitude to ACC_W two's complement, keeping FRAC_W fraction bits.
- f(A,B): ADD a+b; SUB a-b; MUL (a*b) with magnitude product >> FRAC_W, truncated toward zero and signed by XOR of the signs; ABSDIFF |a-b|.
- Accumulator overflow wraps mod 2^ACC_W.
- DONE: out_valid = 1 and out_data holds stable. On out_valid & out_ready, go to IDLE; out_valid drops the next cycle.
- Output conversion: sign = acc < 0; magnitude = |acc| low DATA_W-1 bits; -0 is output as +0.
- rst mid-job aborts immediately to the reset state; no partial result is output.
- cfg_valid while not IDLE is ignored (cfg_ready = 0).
- Tag-register wrap-around is legal.

Optional Feature:
NODE_STRIPE_SAT_EN.
- Defined: output magnitude saturates to 2^(DATA_W-1)-1 when |acc| exceeds it; the sign is kept.
- Undefined: magnitude is truncated to its low DATA_W-1 bits.

Decomposition:
- Package node_stripe_pkg: op enum (ADD/SUB/MUL/ABSDIFF), state enum, sm_to_tc and tc_to_sm conversion functions, default widths.
- One sub-module, node_stripe_lane: a single lane's ALU plus accumulator plus output conversion, generated LANES times.
- Control FSM and tag logic live in the top.

Test Plan:
All values use DATA_W=16, FRAC_W=8.
1. ADD, iter_lim=1, tag_a=5, tag_b=6: bus tag5 lane0=0x0100 (1.0), tag6 lane0=0x0280 (2.5) -> out_valid, lane0 = 0x0380 (3.5).
2. MUL, iter_lim=2, stride_a=stride_b=1: A=0x0200 (2.0)/B=0x8180 (-1.5), then A=0x0100 (1.0)/B=0x0100 (1.0) -> lane0 = 0x8200 (-2.0); tags end at base+2.
3. tag_a == tag_b == 9, SUB, iter_lim=1: a single word tag9 with lane0=0x0300 -> lane0 = 0x0000 (+0, never 0x8000).
4. Saturation: ADD, iter_lim=4, A=B=0x7FFF in all 4 steps -> lane0 = 0x7FFF with NODE_STRIPE_SAT_EN, and the wrapped low 15 bits without it.
5. Chain: prev_enable=1, stripe busy -> next_enable=1, cfg_ready=0. Hold out_ready=0 for 5 cycles -> out_data stable; ready pulse -> IDLE.
6. Abort and iter_lim=0: rst during WAIT -> all outputs 0 the next cycle. A cfg with iter_lim=0 -> DONE with out_data = 0.

Source files
------------

// File: rtl/node_stripe_pkg.sv
// Shared types, default widths and sign-magnitude <-> two's-complement helpers
// for the node stripe. Conversions work on a wide carrier so any lane width fits.
package node_stripe_pkg;

  localparam int DEF_LANES  = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;
  localparam int DEF_TAG_W  = 12;
  localparam int CONV_W     = 64;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_MUL     = 2'b10,
    OP_ABSDIFF = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_e;

  // Sign-magnitude word (data_w bits, zero-extended) to a signed carrier value.
  function automatic logic signed [CONV_W-1:0] sm_to_tc(input logic [CONV_W-1:0] sm,
                                                         input int data_w);
    logic [CONV_W-1:0] mag;
    mag = sm & ((CONV_W'(1) << (data_w - 1)) - CONV_W'(1));
    return sm[data_w-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Signed carrier value back to sign-magnitude; a zero magnitude is always +0.
  function automatic logic [CONV_W-1:0] tc_to_sm(input logic signed [CONV_W-1:0] tc,
                                                 input int data_w,
                                                 input bit sat);
    logic [CONV_W-1:0] limit;
    logic [CONV_W-1:0] mag;
    logic              neg;
    limit = (CONV_W'(1) << (data_w - 1)) - CONV_W'(1);
    neg   = tc[CONV_W-1];
    mag   = neg ? CONV_W'(-tc) : CONV_W'(tc);
    if (sat && (mag > limit)) begin
      mag = limit;
    end else begin
      mag = mag & limit;
    end
    return ((neg && (mag != '0)) ? (CONV_W'(1) << (data_w - 1)) : '0) | mag;
  endfunction

endpackage

// File: rtl/node_stripe_gen_if.sv
// Config, broadcast-bus and result handshake bundle of a node stripe.
// The slave modport is the stripe itself; master is the job/bus/result side.
interface node_stripe_gen_if
  import node_stripe_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
);

  logic                    cfg_valid;
  logic                    cfg_ready;
  op_e                     cfg_op;
  logic [TAG_W-1:0]        cfg_tag_a;
  logic [TAG_W-1:0]        cfg_tag_b;
  logic [TAG_W-1:0]        cfg_stride_a;
  logic [TAG_W-1:0]        cfg_stride_b;
  logic [TAG_W-1:0]        cfg_iter_lim;

  logic                    bus_valid;
  logic [TAG_W-1:0]        bus_tag;
  logic [LANES*DATA_W-1:0] bus_data;
  logic                    match_drop;

  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;

  modport master (
    output cfg_valid, cfg_op, cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b,
           cfg_iter_lim, bus_valid, bus_tag, bus_data, out_ready,
    input  cfg_ready, match_drop, out_valid, out_data
  );

  modport slave (
    input  cfg_valid, cfg_op, cfg_tag_a, cfg_tag_b, cfg_stride_a, cfg_stride_b,
           cfg_iter_lim, bus_valid, bus_tag, bus_data, out_ready,
    output cfg_ready, match_drop, out_valid, out_data
  );

endinterface

// File: rtl/node_stripe_lane.sv
// One stripe lane: sign-magnitude ALU, wrapping accumulator and output conversion.
// Define NODE_STRIPE_SAT_EN to saturate the output magnitude instead of truncating it.
module node_stripe_lane
  import node_stripe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int ACC_W  = 2 * DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
);

`ifdef NODE_STRIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = 2 * MAG_W;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] a_tc;
  logic signed [ACC_W-1:0] b_tc;
  logic signed [ACC_W-1:0] diff;
  logic signed [ACC_W-1:0] mul_mag;
  logic signed [ACC_W-1:0] term;
  logic [PROD_W-1:0]       mag_prod;

  // MUL works on magnitudes so the fraction shift truncates toward zero.
  always_comb begin
    a_tc     = ACC_W'(sm_to_tc(CONV_W'(a), DATA_W));
    b_tc     = ACC_W'(sm_to_tc(CONV_W'(b), DATA_W));
    diff     = a_tc - b_tc;
    mag_prod = PROD_W'(a[MAG_W-1:0]) * PROD_W'(b[MAG_W-1:0]);
    mul_mag  = ACC_W'(mag_prod >> FRAC_W);
    term     = '0;
    case (op)
      OP_ADD:     term = a_tc + b_tc;
      OP_SUB:     term = diff;
      OP_MUL:     term = (a[DATA_W-1] ^ b[DATA_W-1]) ? -mul_mag : mul_mag;
      OP_ABSDIFF: term = diff[ACC_W-1] ? -diff : diff;
      default:    term = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc + term;
    end
  end

  assign res = DATA_W'(tc_to_sm(CONV_W'(acc), DATA_W, SAT));

endmodule

// File: rtl/node_stripe_gen.sv
// Node stripe top: tag-matching operand capture, job FSM and LANES parallel lanes.
// Output saturation is selected per lane with NODE_STRIPE_SAT_EN.
module node_stripe_gen
  import node_stripe_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_enable,
  output logic              next_enable,
  node_stripe_gen_if.slave  stripe
);

  state_e                  state;
  state_e                  state_nxt;
  op_e                     op;
  logic [TAG_W-1:0]        tag_a;
  logic [TAG_W-1:0]        tag_b;
  logic [TAG_W-1:0]        stride_a;
  logic [TAG_W-1:0]        stride_b;
  logic [TAG_W-1:0]        iter_lim;
  logic [TAG_W-1:0]        iter_count;
  logic                    a_ok;
  logic                    b_ok;
  logic [LANES*DATA_W-1:0] a_word;
  logic [LANES*DATA_W-1:0] b_word;
  logic [LANES*DATA_W-1:0] lane_res;

  logic cfg_fire;
  logic hit_a;
  logic hit_b;
  logic step;
  logic last_step;

  // A step happens in the cycle after both operands are held.
  always_comb begin
    cfg_fire  = stripe.cfg_valid && stripe.cfg_ready;
    hit_a     = stripe.bus_valid && (stripe.bus_tag == tag_a);
    hit_b     = stripe.bus_valid && (stripe.bus_tag == tag_b);
    step      = (state == WAIT) && a_ok && b_ok;
    last_step = step && ((iter_count + TAG_W'(1)) == iter_lim);
  end

  assign stripe.cfg_ready  = prev_enable && (state == IDLE);
  assign next_enable       = prev_enable && (state != IDLE);
  assign stripe.match_drop = step && (hit_a || hit_b);
  assign stripe.out_valid  = (state == DONE);
  assign stripe.out_data   = (state == DONE) ? lane_res : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_fire) begin
          state_nxt = (stripe.cfg_iter_lim == '0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (stripe.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Matches seen during the step cycle are dropped; the producer must resend.
  always_ff @(posedge clk) begin
    if (rst) begin
      op         <= OP_ADD;
      tag_a      <= '0;
      tag_b      <= '0;
      stride_a   <= '0;
      stride_b   <= '0;
      iter_lim   <= '0;
      iter_count <= '0;
      a_ok       <= 1'b0;
      b_ok       <= 1'b0;
      a_word     <= '0;
      b_word     <= '0;
    end else if (cfg_fire) begin
      op         <= stripe.cfg_op;
      tag_a      <= stripe.cfg_tag_a;
      tag_b      <= stripe.cfg_tag_b;
      stride_a   <= stripe.cfg_stride_a;
      stride_b   <= stripe.cfg_stride_b;
      iter_lim   <= stripe.cfg_iter_lim;
      iter_count <= '0;
      a_ok       <= 1'b0;
      b_ok       <= 1'b0;
    end else if (step) begin
      a_ok       <= 1'b0;
      b_ok       <= 1'b0;
      tag_a      <= tag_a + stride_a;
      tag_b      <= tag_b + stride_b;
      iter_count <= iter_count + TAG_W'(1);
    end else if (state == WAIT) begin
      if (hit_a && !a_ok) begin
        a_word <= stripe.bus_data;
        a_ok   <= 1'b1;
      end
      if (hit_b && !b_ok) begin
        b_word <= stripe.bus_data;
        b_ok   <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    node_stripe_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (cfg_fire),
      .step  (step),
      .op    (op),
      .a     (a_word[i*DATA_W +: DATA_W]),
      .b     (b_word[i*DATA_W +: DATA_W]),
      .res   (lane_res[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_node_stripe_gen.sv
// Randomized bench for node_stripe_gen: jobs push model results into a queue
// that a monitor checks on every output handshake.
module tb_node_stripe_gen;
  import node_stripe_pkg::*;

  localparam int LANES  = 8;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 12;
  localparam int BUS_W  = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prev_enable = 1'b1;
  logic next_enable;

  node_stripe_gen_if #(.LANES(LANES), .DATA_W(DATA_W), .TAG_W(TAG_W)) stripe ();

  node_stripe_gen #(.LANES(LANES), .DATA_W(DATA_W), .FRAC_W(8), .TAG_W(TAG_W), .ACC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .prev_enable (prev_enable),
    .next_enable (next_enable),
    .stripe      (stripe)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [BUS_W-1:0] exp_q[$];
  logic [BUS_W-1:0] stim_a[$];
  logic [BUS_W-1:0] stim_b[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [BUS_W-1:0] rndWord();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: lane values as plain integers in units of 2^-8.
  function automatic longint smVal(input logic [15:0] w);
    longint m;
    m = longint'(w[14:0]);
    return w[15] ? -m : m;
  endfunction

  function automatic longint opResult(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    longint x;
    longint y;
    longint p;
    x = smVal(a);
    y = smVal(b);
    case (op)
      2'd0: return x + y;
      2'd1: return x - y;
      2'd2: begin
        p = (longint'(a[14:0]) * longint'(b[14:0])) / 256;
        return (a[15] ^ b[15]) ? -p : p;
      end
      default: return (x > y) ? (x - y) : (y - x);
    endcase
  endfunction

  function automatic longint wrapAcc(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  function automatic logic [15:0] toOut(input longint acc);
    longint mag;
    mag = (acc < 0) ? -acc : acc;
`ifdef NODE_STRIPE_SAT_EN
    if (mag > 32767) mag = 32767;
`else
    mag = mag % 32768;
`endif
    return {((acc < 0) && (mag != 0)), 15'(mag)};
  endfunction

  function automatic logic [TAG_W-1:0] tagAt(input logic [TAG_W-1:0] base, input logic [TAG_W-1:0] stride, input int k);
    return TAG_W'(int'(base) + k * int'(stride));
  endfunction

  // Runs one job using stim_a/stim_b as the per-step operand words.
  task automatic applyStimulus(input logic [1:0] op, input logic [TAG_W-1:0] ta, input logic [TAG_W-1:0] tbase,
                               input logic [TAG_W-1:0] sa, input logic [TAG_W-1:0] sb,
                               input int lim, input int hold);
    logic [BUS_W-1:0] expWord;
    logic [TAG_W-1:0] cta;
    logic [TAG_W-1:0] ctb;
    logic [TAG_W-1:0] noise;
    logic [15:0]      av;
    logic [15:0]      bv;
    longint           acc;
    int               n;

    expWord = '0;
    for (int ln = 0; ln < LANES; ln++) begin
      acc = 0;
      for (int k = 0; k < lim; k++) begin
        av  = stim_a[k][ln*16 +: 16];
        bv  = (tagAt(ta, sa, k) == tagAt(tbase, sb, k)) ? av : stim_b[k][ln*16 +: 16];
        acc = wrapAcc(acc + opResult(op, av, bv));
      end
      expWord[ln*16 +: 16] = toOut(acc);
    end
    exp_q.push_back(expWord);

    n = 0;
    while (!stripe.cfg_ready && n < 100) begin
      tick();
      n++;
    end
    checkOutput("cfg_ready_wait", BUS_W'(stripe.cfg_ready), BUS_W'(1));

    stripe.cfg_valid    = 1'b1;
    stripe.cfg_op       = op_e'(op);
    stripe.cfg_tag_a    = ta;
    stripe.cfg_tag_b    = tbase;
    stripe.cfg_stride_a = sa;
    stripe.cfg_stride_b = sb;
    stripe.cfg_iter_lim = TAG_W'(lim);
    tick();
    stripe.cfg_op       = op_e'(~op);
    stripe.cfg_tag_a    = ta + 12'd1;
    stripe.cfg_iter_lim = TAG_W'(lim + 1);
    checkOutput("busy_next_enable", BUS_W'(next_enable), BUS_W'(1));
    checkOutput("busy_cfg_ready", BUS_W'(stripe.cfg_ready), BUS_W'(0));
    tick();
    stripe.cfg_valid = 1'b0;

    for (int k = 0; k < lim; k++) begin
      cta = tagAt(ta, sa, k);
      ctb = tagAt(tbase, sb, k);
      if ($urandom_range(1, 0) == 1) begin
        noise = TAG_W'($urandom);
        while (noise == cta || noise == ctb) noise = TAG_W'($urandom);
        stripe.bus_valid = 1'b1;
        stripe.bus_tag   = noise;
        stripe.bus_data  = rndWord();
        tick();
      end
      stripe.bus_valid = 1'b1;
      stripe.bus_tag   = cta;
      stripe.bus_data  = stim_a[k];
      tick();
      if (cta != ctb) begin
        stripe.bus_tag  = ctb;
        stripe.bus_data = stim_b[k];
        tick();
      end
      if ($urandom_range(1, 0) == 1) begin
        stripe.bus_valid = 1'b1;
        stripe.bus_tag   = ($urandom_range(1, 0) == 1) ? cta : ctb;
        stripe.bus_data  = rndWord();
        #1;
        checkOutput("match_drop_step", BUS_W'(stripe.match_drop), BUS_W'(1));
      end else begin
        stripe.bus_valid = 1'b0;
        #1;
        checkOutput("match_drop_quiet", BUS_W'(stripe.match_drop), BUS_W'(0));
      end
      tick();
      stripe.bus_valid = 1'b0;
    end

    n = 0;
    while (!stripe.out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("out_valid_wait", BUS_W'(stripe.out_valid), BUS_W'(1));
    if (!stripe.out_valid) begin
      void'(exp_q.pop_back());
      return;
    end
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_stable", stripe.out_data, expWord);
      tick();
    end
    stripe.out_ready = 1'b1;
    tick();
    stripe.out_ready = 1'b0;
    checkOutput("valid_drop", BUS_W'(stripe.out_valid), BUS_W'(0));
    checkOutput("idle_cfg_ready", BUS_W'(stripe.cfg_ready), BUS_W'(1));
  endtask

  // Monitor: every accepted result is compared with the oldest model result.
  always @(negedge clk) begin
    if (stripe.out_valid && stripe.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_result", BUS_W'(1), BUS_W'(0));
      end else begin
        checkOutput("result", stripe.out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BUS_W-1:0] w;
    logic [BUS_W-1:0] wb;
    logic [TAG_W-1:0] ta;
    logic [TAG_W-1:0] tbv;
    logic [TAG_W-1:0] sa;
    logic [TAG_W-1:0] sb;
    int               lim;

    stripe.cfg_valid    = 1'b0;
    stripe.cfg_op       = OP_ADD;
    stripe.cfg_tag_a    = '0;
    stripe.cfg_tag_b    = '0;
    stripe.cfg_stride_a = '0;
    stripe.cfg_stride_b = '0;
    stripe.cfg_iter_lim = '0;
    stripe.bus_valid    = 1'b0;
    stripe.bus_tag      = '0;
    stripe.bus_data     = '0;
    stripe.out_ready    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    checkOutput("reset_out_valid", BUS_W'(stripe.out_valid), BUS_W'(0));
    checkOutput("reset_out_data", stripe.out_data, '0);
    checkOutput("reset_match_drop", BUS_W'(stripe.match_drop), BUS_W'(0));
    checkOutput("reset_next_enable", BUS_W'(next_enable), BUS_W'(0));
    checkOutput("reset_cfg_ready", BUS_W'(stripe.cfg_ready), BUS_W'(1));

    prev_enable      = 1'b0;
    stripe.cfg_valid = 1'b1;
    #1;
    checkOutput("no_token_cfg_ready", BUS_W'(stripe.cfg_ready), BUS_W'(0));
    tick();
    stripe.cfg_valid = 1'b0;
    prev_enable      = 1'b1;
    #1;
    checkOutput("no_token_ignored", BUS_W'(stripe.cfg_ready), BUS_W'(1));

    // Plan 1: ADD 1.0 + 2.5 on lane0, held five cycles before acceptance.
    stim_a.delete(); stim_b.delete();
    w = rndWord(); w[15:0] = 16'h0100; stim_a.push_back(w);
    w = rndWord(); w[15:0] = 16'h0280; stim_b.push_back(w);
    applyStimulus(2'd0, 12'd5, 12'd6, 12'd0, 12'd0, 1, 5);

    // Plan 2: MUL 2.0 * -1.5 then 1.0 * 1.0.
    stim_a.delete(); stim_b.delete();
    w = rndWord(); w[15:0] = 16'h0200; stim_a.push_back(w);
    w = rndWord(); w[15:0] = 16'h8180; stim_b.push_back(w);
    w = rndWord(); w[15:0] = 16'h0100; stim_a.push_back(w);
    w = rndWord(); w[15:0] = 16'h0100; stim_b.push_back(w);
    applyStimulus(2'd2, 12'd100, 12'd200, 12'd1, 12'd1, 2, 1);

    // Plan 3: shared tag, SUB of a word with itself must give +0.
    stim_a.delete(); stim_b.delete();
    w = rndWord(); w[15:0] = 16'h0300; stim_a.push_back(w); stim_b.push_back(w);
    applyStimulus(2'd1, 12'd9, 12'd9, 12'd0, 12'd0, 1, 0);

    // Plan 4: ADD of full-scale words overflows the output magnitude.
    stim_a.delete(); stim_b.delete();
    w = {LANES{16'h7FFF}};
    repeat (4) begin stim_a.push_back(w); stim_b.push_back(w); end
    applyStimulus(2'd0, 12'd30, 12'd31, 12'd2, 12'd2, 4, 0);

    // Abort mid-job: rst during WAIT returns every output to idle values.
    stripe.cfg_valid    = 1'b1;
    stripe.cfg_op       = OP_ADD;
    stripe.cfg_tag_a    = 12'd20;
    stripe.cfg_tag_b    = 12'd21;
    stripe.cfg_stride_a = 12'd1;
    stripe.cfg_stride_b = 12'd1;
    stripe.cfg_iter_lim = 12'd2;
    tick();
    stripe.cfg_valid = 1'b0;
    stripe.bus_valid = 1'b1;
    stripe.bus_tag   = 12'd20;
    stripe.bus_data  = rndWord();
    tick();
    stripe.bus_valid = 1'b0;
    prev_enable      = 1'b0;
    #1;
    checkOutput("busy_no_token_next_enable", BUS_W'(next_enable), BUS_W'(0));
    prev_enable = 1'b1;
    #1;
    checkOutput("abort_busy_next_enable", BUS_W'(next_enable), BUS_W'(1));
    rst = 1'b1;
    tick();
    checkOutput("abort_out_valid", BUS_W'(stripe.out_valid), BUS_W'(0));
    checkOutput("abort_out_data", stripe.out_data, '0);
    checkOutput("abort_match_drop", BUS_W'(stripe.match_drop), BUS_W'(0));
    checkOutput("abort_next_enable", BUS_W'(next_enable), BUS_W'(0));
    checkOutput("abort_cfg_ready", BUS_W'(stripe.cfg_ready), BUS_W'(1));
    rst = 1'b0;
    tick();

    // Zero-length job goes straight to a zero result.
    stim_a.delete(); stim_b.delete();
    applyStimulus(2'd3, 12'd40, 12'd41, 12'd1, 12'd1, 0, 2);

    // Randomized jobs, including zero strides, shared tags and tag wrap.
    for (int j = 0; j < 40; j++) begin
      stim_a.delete(); stim_b.delete();
      ta  = TAG_W'($urandom);
      tbv = ($urandom_range(4, 0) == 0) ? ta : TAG_W'($urandom);
      sa  = ($urandom_range(3, 0) == 0) ? '0 : TAG_W'($urandom);
      sb  = ($urandom_range(3, 0) == 0) ? '0 : TAG_W'($urandom);
      lim = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(4, 1));
      for (int k = 0; k < lim; k++) begin
        w  = rndWord();
        wb = rndWord();
        stim_a.push_back(w);
        stim_b.push_back(wb);
      end
      applyStimulus(2'($urandom), ta, tbv, sa, sb, lim, int'($urandom_range(3, 0)));
    end

    repeat (3) tick();
    checkOutput("scoreboard_drain", BUS_W'(exp_q.size()), BUS_W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
